dm_access_unit: RTL and testbench

//  Initiator-side load/store unit for the MEM stage of the pipeline. It takes one load or store
//  (MIPS opcode, byte address, store data) from the pipeline, and drives a word-organised data

---
 rtl/dm_access_unit.sv | 162 ++++++++++++++++
 tb/tb_dm_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// dm_access_unit: MEM-stage load/store initiator driving a word-wide data memory over req/ack.
// Handles byte-lane steering, load extension, misalignment detection and ack timeout.
`default_nettype none

module dm_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ld_size;
  logic             ld_uns;
  logic [1:0]       ld_lane;

  // op_size: 0 byte, 1 half, 2 word
  logic       op_legal, op_store, op_uns;
  logic [1:0] op_size;
  logic       misalign, accept, timeout_hit;
  logic [3:0] be_c;
  logic [31:0] wdata_c, shifted, load_ext;

  always_comb begin
    op_legal = 1'b1;
    op_store = 1'b0;
    op_uns   = 1'b0;
    op_size  = 2'd0;
    case (req_op)
      6'b100000: op_size = 2'd0;
      6'b100001: op_size = 2'd1;
      6'b100011: op_size = 2'd2;
      6'b100100: op_uns  = 1'b1;
      6'b100101: begin op_size = 2'd1; op_uns = 1'b1; end
      6'b101000: op_store = 1'b1;
      6'b101001: begin op_store = 1'b1; op_size = 2'd1; end
      6'b101011: begin op_store = 1'b1; op_size = 2'd2; end
      default:   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (op_size)
      2'd0: begin
        wdata_c = {4{req_wdata[7:0]}};
        if (op_store) be_c = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        wdata_c = {2{req_wdata[15:0]}};
        if (op_store) be_c = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign misalign    = ((op_size == 2'd1) && req_addr[0]) ||
                       ((op_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign accept      = (state == IDLE) && req_valid && op_legal;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Selected lane is shifted down to bit 0 before extension
  assign shifted = dm_rdata >> {ld_lane, 3'b000};
  always_comb begin
    case (ld_size)
      2'd0:    load_ext = ld_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_ext = ld_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = dm_rdata;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign dm_req     = (state == REQ);
  assign resp_valid = (state == RESP);
  assign stall      = accept || (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = misalign ? RESP : REQ;
      REQ:     if (dm_ack || timeout_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      ld_size    <= 2'd0;
      ld_uns     <= 1'b0;
      ld_lane    <= 2'd0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_be      <= 4'd0;
      dm_wdata   <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 2'b00;
    end else begin
      cnt <= (state == REQ) ? cnt + 1'b1 : '0;
      if (accept) begin
        ld_size    <= op_size;
        ld_uns     <= op_uns;
        ld_lane    <= req_addr[1:0];
        resp_rdata <= 32'd0;
        if (misalign) begin
          resp_err <= 2'b01;
        end else begin
          resp_err <= 2'b00;
          dm_we    <= op_store;
          dm_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          dm_be    <= be_c;
          dm_wdata <= wdata_c;
        end
      end else if (state == REQ) begin
        // Ack beats expiry when both land on the same edge
        if (dm_ack) begin
          resp_rdata <= dm_we ? 32'd0 : load_ext;
          resp_err   <= 2'b00;
        end else if (timeout_hit) begin
          resp_rdata <= 32'd0;
          resp_err   <= 2'b10;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_unit.sv
// Scoreboarded random bench for dm_access_unit: a byte-addressed reference memory predicts
// the memory-side transaction and the response of every request.
`default_nettype none

module tb_dm_access_unit;
  localparam int ADDR_W = 32;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [5:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_err;
  logic              stall, dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata, dm_rdata;
  logic              dm_ack;

  dm_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          wait_c;
  } dm_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } resp_exp_t;

  dm_exp_t   dm_q[$];
  resp_exp_t resp_q[$];
  logic [7:0] ref_mem[64];
  logic [7:0] mem[64];
  int  vectors = 0;
  int  miscompares = 0;
  bit  directed = 1'b0;
  logic [5:0] legal_ops[8] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                               6'b100101, 6'b101000, 6'b101001, 6'b101011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // Predict from byte-level memory semantics, then present the request for one cycle
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d,
                       input int wt, output longint t_acc);
    int nb; bit sgn, st; dm_exp_t e; resp_exp_t r; logic [31:0] val; int off;
    nb = 1; sgn = 0; st = 0;
    case (op)
      6'b100000: begin nb = 1; sgn = 1; end
      6'b100001: begin nb = 2; sgn = 1; end
      6'b100011: nb = 4;
      6'b100100: nb = 1;
      6'b100101: nb = 2;
      6'b101000: begin nb = 1; st = 1; end
      6'b101001: begin nb = 2; st = 1; end
      default:   begin nb = 4; st = 1; end
    endcase
    off = int'(addr[1:0]);
    r.rdata = 32'd0;
    if ((off % nb) != 0) begin
      r.err = 2'b01;
    end else begin
      e.addr = addr & 32'hFFFF_FFFC;
      e.we = st;
      e.wait_c = wt;
      for (int i = 0; i < 4; i++) begin
        e.be[i]         = st ? (i >= off && i < off + nb) : 1'b1;
        e.wdata[8*i+:8] = d[8*(i % nb)+:8];
      end
      dm_q.push_back(e);
      if (wt >= TMO) begin
        r.err = 2'b10;
      end else begin
        r.err = 2'b00;
        if (st) begin
          for (int i = 0; i < nb; i++) ref_mem[(int'(addr[5:0]) + i) & 63] = d[8*i+:8];
        end else begin
          val = 32'd0;
          for (int i = 0; i < nb; i++)
            val = val | (32'(ref_mem[(int'(addr[5:0]) + i) & 63]) << (8 * i));
          if (sgn && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
          r.rdata = val;
        end
      end
    end
    resp_q.push_back(r);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = d;
    #1 chk("stall_on_accept", {31'd0, stall}, 32'd1);
    @(posedge clk);
    t_acc = $time;
    #1 req_valid = 1'b0; req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic issue_illegal();
    logic [5:0] op;
    bit hit;
    do begin
      op = 6'($urandom);
      hit = 0;
      foreach (legal_ops[i]) if (legal_ops[i] == op) hit = 1;
    end while (hit);
    wait_ready();
    req_valid = 1'b1; req_op = op; req_addr = $urandom; req_wdata = $urandom;
    #1 chk("illegal_no_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("illegal_stays_idle", {31'd0, req_ready}, 32'd1);
  endtask

  // Memory responder: checks the request, waits, then acks (or lets it time out)
  initial begin
    dm_exp_t e;
    logic [31:0] w;
    int base;
    dm_ack = 1'b0;
    dm_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!directed) dm_ack = 1'b0;
      if (rst_n && dm_req && !directed) begin
        if (dm_q.size() == 0) begin
          chk("dm_req_unexpected", {31'd0, dm_req}, 32'd0);
        end else begin
          e = dm_q.pop_front();
          chk("dm_addr", dm_addr, e.addr);
          chk("dm_be", {28'd0, dm_be}, {28'd0, e.be});
          chk("dm_we", {31'd0, dm_we}, {31'd0, e.we});
          if (e.we) chk("dm_wdata", dm_wdata, e.wdata);
          chk("stall_in_req", {31'd0, stall}, 32'd1);
          base = int'(dm_addr[5:0]);
          for (int k = 0; k < TMO; k++) begin
            if (k > 0) begin
              @(negedge clk);
              chk("dm_req_held", {31'd0, dm_req}, 32'd1);
            end
            if (k == e.wait_c) begin
              for (int i = 0; i < 4; i++) w[8*i+:8] = mem[base + i];
              dm_rdata = w;
              dm_ack = 1'b1;
              if (dm_we)
                for (int i = 0; i < 4; i++) if (dm_be[i]) mem[base + i] = dm_wdata[8*i+:8];
              break;
            end
          end
          @(negedge clk);
          dm_ack = 1'b0;
          dm_rdata = $urandom;
          chk("dm_req_release", {31'd0, dm_req}, 32'd0);
        end
      end else if (!directed) begin
        dm_ack = ($urandom_range(0, 3) == 0);
        dm_rdata = $urandom;
      end
    end
  end

  // Response monitor
  initial begin
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {30'd0, resp_err}, {30'd0, r.err});
          chk("stall_in_resp", {31'd0, stall}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0, t1, t2;
    int wt, n;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_addr = '0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    chk("rst_resp", {resp_rdata[29:0], resp_err}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;

    issue(6'b101011, 32'h10, 32'hDEADBEEF, 3, t0);
    issue(6'b101000, 32'h13, 32'h000000A5, 0, t0);
    issue(6'b101011, 32'h10, 32'h11803344, 1, t0);
    issue(6'b100000, 32'h12, 32'h0, 0, t0);
    issue(6'b100100, 32'h12, 32'h0, 2, t0);
    issue(6'b100001, 32'h12, 32'h0, 0, t0);
    issue(6'b100011, 32'h06, 32'h0, 0, t0);
    issue(6'b101001, 32'h05, 32'h1234, 0, t0);
    issue(6'b100011, 32'h20, 32'h0, TMO, t0);
    issue(6'b100011, 32'h24, 32'h0, TMO - 1, t0);
    issue(6'b100011, 32'h0, 32'h0, 0, t0);
    issue(6'b100011, 32'h4, 32'h0, 0, t1);
    issue(6'b100011, 32'h8, 32'h0, 0, t2);
    chk("b2b_spacing_a", 32'((t1 - t0) / 10), 32'd3);
    chk("b2b_spacing_b", 32'((t2 - t1) / 10), 32'd3);

    for (int it = 0; it < 160; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        issue_illegal();
      end else begin
        n = $urandom_range(0, 9);
        wt = (n < 6) ? $urandom_range(0, 3) : (n == 6) ? TMO - 1 :
             (n == 7) ? TMO : $urandom_range(4, 14);
        req_addr = $urandom;
        if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
        issue(legal_ops[$urandom_range(0, 7)], req_addr, $urandom, wt, t0);
      end
    end

    n = 0;
    while ((resp_q.size() != 0 || dm_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_q_drained", resp_q.size(), 32'd0);
    chk("dm_q_drained", dm_q.size(), 32'd0);

    // Reset in the middle of a memory access
    wait_ready();
    directed = 1'b1;
    dm_ack = 1'b0;
    req_valid = 1'b1; req_op = 6'b100011; req_addr = 32'h20; req_wdata = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("midreq_dm_req", {31'd0, dm_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("midreq_rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("midreq_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    dm_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dm_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("postrst_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("postrst_no_req", {31'd0, dm_req}, 32'd0);
      @(negedge clk);
    end
    chk("postrst_ready", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
